spi_reg_master: RTL and testbench
=================================

SPI_REG_MASTER -- requirements
Module: spi_reg_master

Interface
REQ-001: Parameter HALF_DIV, default 2: i_clk cycles per SCLK half-period; legal range 1..255.
REQ-002: Parameter CMD_W, default 4: command field width in bits.
REQ-003: Parameter DATA_W, default 24: payload field width in bits.
REQ-004: i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005: i_reset_n  input  1  reset, synchronous and active-low.
REQ-006: i_valid  input  1  frame request.
REQ-007: i_cmd  input  CMD_W  command field, sent first.
REQ-008: i_data  input  DATA_W  payload field, sent after i_cmd.
REQ-009: o_ready  output  1  high only when a new frame can be accepted.
REQ-010: o_done  output  1  one-cycle pulse when a frame completes.
REQ-011: o_csb  output  1  SPI chip select, active-low; drives the raybox i_reg_csb.
REQ-012: o_sclk  output  1  SPI clock, idle low; drives i_reg_sclk.
REQ-013: o_mosi  output  1  SPI data out; drives i_reg_mosi.

Function
REQ-014: All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-015: Acceptance SHALL occur on a rising edge where i_valid=1 and o_ready=1.
- On acceptance, {i_cmd,i_data} is latched into a shift register of width N=CMD_W+DATA_W.
REQ-016: Latched bits SHALL be transmitted MSB first, in SPI mode 0.
- o_mosi changes only while o_sclk is low.
- The receiver samples on the o_sclk rising edge.
REQ-017: The state machine SHALL have states IDLE, SETUP, SCLK_HI, SCLK_LO, GAP, with these transitions:
- IDLE->SETUP on acceptance.
- SETUP->SCLK_HI after HALF_DIV cycles.
- SCLK_HI->SCLK_LO after HALF_DIV cycles.
- SCLK_LO->SCLK_HI after HALF_DIV cycles if bits remain, else SCLK_LO->GAP.
- GAP->IDLE after 2*HALF_DIV cycles.
REQ-018: In SETUP, the block SHALL drive o_csb=0, o_sclk=0, o_mosi=bit N-1, starting the cycle after acceptance.
REQ-019: In SCLK_HI, the block SHALL drive o_sclk=1 and hold o_mosi stable.
REQ-020: In SCLK_LO, the block SHALL drive o_sclk=0, with o_mosi advanced to the next bit on the first SCLK_LO cycle.
- After the last bit, SCLK_LO acts as CSB hold and o_mosi keeps the last bit.
REQ-021: In GAP and IDLE, the block SHALL drive o_csb=1, o_sclk=0, o_mosi=0.
REQ-022: Each frame SHALL produce exactly N o_sclk rising edges.
REQ-023: o_ready SHALL be 1 only in IDLE.
- It is low for exactly (2N+3)*HALF_DIV cycles per frame: 118 cycles with default parameters.
REQ-024: o_done SHALL be 1 for exactly the first GAP cycle of each completed frame, and 0 otherwise.
REQ-025: i_valid while o_ready=0 SHALL be ignored.
- Nothing is latched or queued.
- Changes to i_cmd/i_data after acceptance SHALL NOT affect the frame in progress.
REQ-026: i_valid held high continuously SHALL be accepted on the first cycle o_ready=1.
- The first o_csb-high gap between frames is then exactly 2*HALF_DIV+1 cycles.
REQ-027: Internal counters SHALL be sized to handle HALF_DIV=255 and N up to 64 without wrap-around.

Reset
REQ-028: While i_reset_n=0 at a rising edge, the next state SHALL be IDLE with o_csb=1, o_sclk=0, o_mosi=0, o_done=0, o_ready=1.
REQ-029: Reset asserted mid-frame SHALL abort the frame.
- Takes effect on the next edge, with no o_done pulse and no further o_sclk edges.
REQ-030: An i_valid present while i_reset_n=0 SHALL NOT be accepted.

Verification
REQ-031: Default params, i_cmd=4'h3, i_data=24'hA5C3F0, one-cycle i_valid -> expected response:
- Bench samples 28 rising edges on o_sclk, giving 28'h3A5C3F0.
- o_csb low for 114 cycles.
- One o_done pulse.
- o_ready low for 118 cycles.
REQ-032: i_valid held high with two different words -> expected response:
- Both frames sent intact and in order.
- o_csb high for exactly 5 cycles between the two frames.
- Two o_done pulses.
REQ-033: i_valid pulsed with i_cmd=4'hF during a frame in progress -> expected response:
- No change to the frame in progress.
- No second frame follows.
REQ-034: i_reset_n=0 for one cycle after the 10th o_sclk rise -> expected response:
- o_csb=1 and o_sclk=0 on the next cycle.
- No o_done.
- o_ready=1.
- A subsequent frame transmits correctly.
REQ-035: HALF_DIV=1, i_data=24'hFFFFFF, i_cmd=4'h0 -> expected response:
- o_ready low for 59 cycles.
- o_sclk period 2 cycles.
- Bits = 4 zeros then 24 ones.
REQ-036: Scoreboard on every frame -> o_mosi stable whenever o_sclk=1, and no o_sclk edge while o_csb=1.

Source files
------------

// File: rtl/spi_reg_master.sv
// SPI mode-0 register-write master: sends {cmd,data} MSB first inside one CSB-low frame.
// Every output is a flop; o_ready is high only in IDLE and requests seen while busy are dropped.
module spi_reg_master #(
  parameter int HALF_DIV = 2,
  parameter int CMD_W    = 4,
  parameter int DATA_W   = 24
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_valid,
  input  logic [CMD_W-1:0]  i_cmd,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_done,
  output logic              o_csb,
  output logic              o_sclk,
  output logic              o_mosi
);

  localparam int N = CMD_W + DATA_W;
  // 9-bit count covers the 2*255-cycle gap; 7-bit bit count covers frames up to 64 bits
  localparam logic [8:0] HALF_LAST = 9'(HALF_DIV - 1);
  localparam logic [8:0] GAP_LAST  = 9'(2 * HALF_DIV - 1);
  localparam logic [6:0] BITS_INIT = 7'(N - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SCLK_HI, SCLK_LO, GAP} state_t;

  state_t       state;
  logic [8:0]   cnt;
  logic [6:0]   bits_left;
  logic [N-1:0] shreg;
  logic [N-1:0] frame;

  assign frame = {i_cmd, i_data};

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bits_left <= '0;
      shreg     <= '0;
      o_ready   <= 1'b1;
      o_done    <= 1'b0;
      o_csb     <= 1'b1;
      o_sclk    <= 1'b0;
      o_mosi    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid && o_ready) begin
            state     <= SETUP;
            cnt       <= '0;
            bits_left <= BITS_INIT;
            shreg     <= frame;
            o_ready   <= 1'b0;
            o_csb     <= 1'b0;
            o_sclk    <= 1'b0;
            o_mosi    <= frame[N-1];
          end
        end
        SETUP: begin
          if (cnt == HALF_LAST) begin
            cnt    <= '0;
            state  <= SCLK_HI;
            o_sclk <= 1'b1;
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
        SCLK_HI: begin
          if (cnt == HALF_LAST) begin
            cnt    <= '0;
            state  <= SCLK_LO;
            o_sclk <= 1'b0;
            // after the last bit, mosi holds its value through the CSB hold phase
            if (bits_left != 7'd0) begin
              o_mosi <= shreg[N-2];
              shreg  <= shreg << 1;
            end
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
        SCLK_LO: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (bits_left != 7'd0) begin
              bits_left <= bits_left - 7'd1;
              state     <= SCLK_HI;
              o_sclk    <= 1'b1;
            end else begin
              state  <= GAP;
              o_csb  <= 1'b1;
              o_mosi <= 1'b0;
              o_done <= 1'b1;
            end
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt     <= '0;
            state   <= IDLE;
            o_ready <= 1'b1;
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_master.sv
// Bench for spi_reg_master: a default instance (HALF_DIV=2) and a fast instance (HALF_DIV=1),
// each watched by an SPI-receiver style monitor that rebuilds frames from the pins.
module tb_spi_reg_master;

  typedef struct {
    logic [63:0] cap;
    int nedges;
    int csb_low;
    int gap_before;
    int per_min;
    int per_max;
  } frame_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n, rst1_n, valid0, valid1;
  logic [3:0] cmd0, cmd1;
  logic [23:0] data0, data1;
  logic ready0, done0, csb0, sclk0, mosi0;
  logic ready1, done1, csb1, sclk1, mosi1;

  spi_reg_master #(.HALF_DIV(2), .CMD_W(4), .DATA_W(24)) dut0 (
    .i_clk(clk), .i_reset_n(rst0_n), .i_valid(valid0), .i_cmd(cmd0), .i_data(data0),
    .o_ready(ready0), .o_done(done0), .o_csb(csb0), .o_sclk(sclk0), .o_mosi(mosi0));

  spi_reg_master #(.HALF_DIV(1), .CMD_W(4), .DATA_W(24)) dut1 (
    .i_clk(clk), .i_reset_n(rst1_n), .i_valid(valid1), .i_cmd(cmd1), .i_data(data1),
    .o_ready(ready1), .o_done(done1), .o_csb(csb1), .o_sclk(sclk1), .o_mosi(mosi1));

  int checks = 0;
  int errors = 0;

  // receiver-side monitor state, one slot per instance
  int viol[2], done_cnt[2], ne[2], low_run[2], high_run[2], rdy_run[2];
  int last_rise[2], pmin[2], pmax[2], gap_b[2];
  logic [63:0] cap[2];
  logic p_csb[2] = '{1'b1, 1'b1};
  logic p_sclk[2] = '{1'b0, 1'b0};
  logic p_mosi[2] = '{1'b0, 1'b0};
  logic p_rdy[2] = '{1'b1, 1'b1};
  int cyc = 0;
  int iv;
  logic mc, ms, mm, md, mr;
  frame_t mon_f;
  frame_t fq0[$], fq1[$];
  int rq0[$], rq1[$];

  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      mc = d ? csb1 : csb0;   ms = d ? sclk1 : sclk0;  mm = d ? mosi1 : mosi0;
      md = d ? done1 : done0; mr = d ? ready1 : ready0;
      if (ms != p_sclk[d] && mc && p_csb[d]) viol[d]++;
      if (ms && mm !== p_mosi[d]) viol[d]++;
      if (md && !(mc && !p_csb[d])) viol[d]++;
      if (md) done_cnt[d]++;
      if (!mc) begin
        if (p_csb[d]) begin
          gap_b[d] = high_run[d]; cap[d] = '0; ne[d] = 0; low_run[d] = 0;
          last_rise[d] = -1; pmin[d] = 100000; pmax[d] = 0;
        end
        low_run[d]++;
        if (ms && !p_sclk[d]) begin
          cap[d] = {cap[d][62:0], p_mosi[d]};
          ne[d]++;
          if (last_rise[d] >= 0) begin
            iv = cyc - last_rise[d];
            if (iv < pmin[d]) pmin[d] = iv;
            if (iv > pmax[d]) pmax[d] = iv;
          end
          last_rise[d] = cyc;
        end
      end else if (!p_csb[d]) begin
        mon_f.cap = cap[d]; mon_f.nedges = ne[d]; mon_f.csb_low = low_run[d];
        mon_f.gap_before = gap_b[d]; mon_f.per_min = pmin[d]; mon_f.per_max = pmax[d];
        if (d == 0) fq0.push_back(mon_f); else fq1.push_back(mon_f);
        high_run[d] = 1;
      end else begin
        high_run[d]++;
      end
      if (!mr) rdy_run[d] = p_rdy[d] ? 1 : rdy_run[d] + 1;
      else if (!p_rdy[d]) begin
        if (d == 0) rq0.push_back(rdy_run[d]); else rq1.push_back(rdy_run[d]);
      end
      p_csb[d] = mc; p_sclk[d] = ms; p_mosi[d] = mm; p_rdy[d] = mr;
    end
  end

  function automatic int hd(input int d);
    return d ? 1 : 2;
  endfunction

  function automatic logic [4:0] outs(input int d);
    return d ? {ready1, done1, csb1, sclk1, mosi1} : {ready0, done0, csb0, sclk0, mosi0};
  endfunction

  function automatic int fq_size(input int d);
    return d ? fq1.size() : fq0.size();
  endfunction

  function automatic int rq_size(input int d);
    return d ? rq1.size() : rq0.size();
  endfunction

  function automatic frame_t pop_frame(input int d);
    frame_t f;
    f.cap = '0; f.nedges = -1; f.csb_low = -1; f.gap_before = -1; f.per_min = -1; f.per_max = -1;
    if (d == 0) begin
      if (fq0.size() > 0) f = fq0.pop_front();
    end else if (fq1.size() > 0) f = fq1.pop_front();
    return f;
  endfunction

  function automatic int pop_rdy(input int d);
    int r;
    r = -1;
    if (d == 0) begin
      if (rq0.size() > 0) r = rq0.pop_front();
    end else if (rq1.size() > 0) r = rq1.pop_front();
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic v, input logic [3:0] c, input logic [23:0] x);
    if (d == 0) begin valid0 = v; cmd0 = c; data0 = x; end
    else begin valid1 = v; cmd1 = c; data1 = x; end
  endtask

  // offer one frame for a single cycle once ready, then scramble the inputs
  task automatic send(input int d, input logic [3:0] c, input logic [23:0] x);
    bit ok;
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      if (outs(d)[4]) begin ok = 1; break; end
      tick();
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL send_timeout dut%0d ready stayed 0, want 1", d); end
    drive(d, 1'b1, c, x);
    tick();
    drive(d, 1'b0, 4'($urandom), 24'($urandom));
  endtask

  task automatic wait_frames(input int d, input int n);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (fq_size(d) >= n && rq_size(d) >= n) begin ok = 1; break; end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL frame_timeout dut%0d got %0d frames, want %0d", d, fq_size(d), n);
    end
  endtask

  task automatic test_reset();
    rst0_n = 0; rst1_n = 0;
    drive(0, 1'b1, 4'hA, 24'h123456);
    drive(1, 1'b1, 4'h5, 24'h654321);
    for (int k = 0; k < 3; k++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (outs(d) !== 5'b10100) begin
          errors++;
          $display("FAIL reset_outs dut%0d {rdy,done,csb,sclk,mosi}=%b want 10100", d, outs(d));
        end
      end
    end
    drive(0, 1'b0, 4'h0, 24'h0);
    drive(1, 1'b0, 4'h0, 24'h0);
    rst0_n = 1; rst1_n = 1;
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (outs(d) !== 5'b10100) begin
        errors++;
        $display("FAIL reset_no_accept dut%0d outs=%b want 10100", d, outs(d));
      end
    end
  endtask

  task automatic test_directed();
    frame_t f;
    int r, dc;
    dc = done_cnt[0];
    send(0, 4'h3, 24'hA5C3F0);
    wait_frames(0, 1);
    f = pop_frame(0);
    r = pop_rdy(0);
    checks++;
    if (f.cap !== 64'h3A5C3F0) begin errors++; $display("FAIL directed_word got %h want 3a5c3f0", f.cap); end
    checks++;
    if (f.nedges !== 28) begin errors++; $display("FAIL directed_edges got %0d want 28", f.nedges); end
    checks++;
    if (f.csb_low !== 114) begin errors++; $display("FAIL directed_csb_low got %0d want 114", f.csb_low); end
    checks++;
    if (r !== 118) begin errors++; $display("FAIL directed_ready_low got %0d want 118", r); end
    checks++;
    if (done_cnt[0] - dc !== 1) begin errors++; $display("FAIL directed_done got %0d want 1", done_cnt[0] - dc); end
    checks++;
    if (f.per_min !== 4 || f.per_max !== 4) begin
      errors++; $display("FAIL directed_period got %0d..%0d want 4", f.per_min, f.per_max);
    end
  endtask

  task automatic test_halfdiv1();
    frame_t f;
    int r, dc;
    dc = done_cnt[1];
    send(1, 4'h0, 24'hFFFFFF);
    wait_frames(1, 1);
    f = pop_frame(1);
    r = pop_rdy(1);
    checks++;
    if (f.cap !== 64'h0FFFFFF) begin errors++; $display("FAIL hd1_word got %h want 0ffffff", f.cap); end
    checks++;
    if (r !== 59) begin errors++; $display("FAIL hd1_ready_low got %0d want 59", r); end
    checks++;
    if (f.per_min !== 2 || f.per_max !== 2) begin
      errors++; $display("FAIL hd1_period got %0d..%0d want 2", f.per_min, f.per_max);
    end
    checks++;
    if (f.csb_low !== 57 || done_cnt[1] - dc !== 1) begin
      errors++; $display("FAIL hd1_csb_done csb_low %0d done %0d want 57 1", f.csb_low, done_cnt[1] - dc);
    end
  endtask

  task automatic test_random(input int d, input int n);
    frame_t f;
    int r, h, dc;
    logic [3:0] c;
    logic [23:0] x;
    h = hd(d);
    for (int k = 0; k < n; k++) begin
      c = 4'($urandom); x = 24'($urandom);
      dc = done_cnt[d];
      repeat ($urandom_range(0, 5)) tick();
      send(d, c, x);
      wait_frames(d, 1);
      f = pop_frame(d);
      r = pop_rdy(d);
      checks++;
      if (f.cap !== {36'd0, c, x}) begin
        errors++; $display("FAIL rand_word dut%0d got %h want %h", d, f.cap, {36'd0, c, x});
      end
      checks++;
      if (f.nedges !== 28 || f.csb_low !== 57 * h) begin
        errors++; $display("FAIL rand_shape dut%0d edges %0d csb_low %0d want 28 %0d", d, f.nedges, f.csb_low, 57 * h);
      end
      checks++;
      if (r !== 59 * h || done_cnt[d] - dc !== 1) begin
        errors++; $display("FAIL rand_ready_done dut%0d ready_low %0d done %0d want %0d 1", d, r, done_cnt[d] - dc, 59 * h);
      end
    end
  endtask

  task automatic test_back_to_back();
    frame_t f1, f2;
    int r1, r2, dc, acc;
    logic [3:0] ca, cb;
    logic [23:0] xa, xb;
    logic rd;
    ca = 4'($urandom); xa = 24'($urandom); cb = ~ca; xb = ~xa;
    dc = done_cnt[0];
    acc = 0;
    drive(0, 1'b1, ca, xa);
    for (int i = 0; i < 1000 && acc < 2; i++) begin
      rd = ready0;
      tick();
      if (rd) begin
        acc++;
        drive(0, 1'b1, cb, xb);
      end
    end
    drive(0, 1'b0, 4'h0, 24'h0);
    wait_frames(0, 2);
    f1 = pop_frame(0); f2 = pop_frame(0);
    r1 = pop_rdy(0); r2 = pop_rdy(0);
    checks++;
    if (f1.cap !== {36'd0, ca, xa}) begin errors++; $display("FAIL b2b_first got %h want %h", f1.cap, {36'd0, ca, xa}); end
    checks++;
    if (f2.cap !== {36'd0, cb, xb}) begin errors++; $display("FAIL b2b_second got %h want %h", f2.cap, {36'd0, cb, xb}); end
    checks++;
    if (f2.gap_before !== 5) begin errors++; $display("FAIL b2b_gap got %0d want 5", f2.gap_before); end
    checks++;
    if (done_cnt[0] - dc !== 2) begin errors++; $display("FAIL b2b_done got %0d want 2", done_cnt[0] - dc); end
    checks++;
    if (r1 !== 118 || r2 !== 118) begin errors++; $display("FAIL b2b_ready_low got %0d %0d want 118 118", r1, r2); end
  endtask

  task automatic test_ignore_busy();
    frame_t f;
    int r, dc;
    logic [23:0] x;
    x = 24'($urandom);
    dc = done_cnt[0];
    send(0, 4'h3, x);
    repeat (20) tick();
    drive(0, 1'b1, 4'hF, 24'($urandom));
    tick();
    drive(0, 1'b0, 4'($urandom), 24'($urandom));
    wait_frames(0, 1);
    f = pop_frame(0);
    r = pop_rdy(0);
    repeat (200) tick();
    checks++;
    if (f.cap !== {36'd0, 4'h3, x}) begin errors++; $display("FAIL busy_word got %h want %h", f.cap, {36'd0, 4'h3, x}); end
    checks++;
    if (fq_size(0) !== 0 || done_cnt[0] - dc !== 1) begin
      errors++; $display("FAIL busy_no_second frames %0d done %0d want 0 1", fq_size(0), done_cnt[0] - dc);
    end
    checks++;
    if (outs(0) !== 5'b10100 || r !== 118) begin
      errors++; $display("FAIL busy_idle outs %b ready_low %0d want 10100 118", outs(0), r);
    end
  endtask

  task automatic test_reset_abort();
    frame_t f;
    int dc, r;
    bit ok;
    logic [3:0] c;
    logic [23:0] x;
    dc = done_cnt[0];
    send(0, 4'($urandom), 24'($urandom));
    tick();
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      if (ne[0] >= 10) begin ok = 1; break; end
      tick();
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_wait edges %0d want 10", ne[0]); end
    rst0_n = 0;
    tick();
    rst0_n = 1;
    checks++;
    if (outs(0) !== 5'b10100) begin errors++; $display("FAIL abort_outs got %b want 10100", outs(0)); end
    wait_frames(0, 1);
    f = pop_frame(0);
    r = pop_rdy(0);
    repeat (100) tick();
    checks++;
    if (f.nedges !== 10) begin errors++; $display("FAIL abort_edges got %0d want 10", f.nedges); end
    checks++;
    if (done_cnt[0] !== dc) begin errors++; $display("FAIL abort_no_done got %0d want 0", done_cnt[0] - dc); end
    c = 4'($urandom); x = 24'($urandom);
    send(0, c, x);
    wait_frames(0, 1);
    f = pop_frame(0);
    r = pop_rdy(0);
    checks++;
    if (f.cap !== {36'd0, c, x} || f.nedges !== 28) begin
      errors++; $display("FAIL abort_next_frame got %h/%0d want %h/28", f.cap, f.nedges, {36'd0, c, x});
    end
    checks++;
    if (done_cnt[0] - dc !== 1 || r !== 118) begin
      errors++; $display("FAIL abort_next_done done %0d ready_low %0d want 1 118", done_cnt[0] - dc, r);
    end
  endtask

  initial begin
    test_reset();
    fq0.delete(); fq1.delete(); rq0.delete(); rq1.delete();
    test_directed();
    test_halfdiv1();
    test_random(0, 6);
    test_random(1, 8);
    test_back_to_back();
    test_ignore_busy();
    test_reset_abort();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (viol[d] !== 0) begin
        errors++; $display("FAIL protocol dut%0d violations %0d want 0", d, viol[d]);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
